// File: rtl/reaction_pkg.sv
// reaction_pkg: shared states, display codes and LFSR constants for the reaction timer.
package reaction_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_RAND, TIMING, RESULT, FALSE_START} state_e;
    localparam logic [3:0] CODE_E = 4'hE;
    localparam logic [3:0] CODE_R = 4'hA;
    localparam logic [3:0] CODE_OFF = 4'hF;
    localparam logic [19:0] NO_BEST = 20'hFFFFF;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/reaction_timer_ctrl_btn_edge_sync.sv
// btn_edge_sync: 2-FF synchronizer for an active-low button plus one-clk press pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n_i,
    output logic press_o
);
    logic [2:0] sync_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 3'b111;
        else          sync_q <= {sync_q[1:0], btn_n_i};
    end
    // sync_q[1] is the synchronized level, sync_q[2] its previous value
    assign press_o = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl: random-delay reaction tester driving the ms/BCD/seven-segment path.
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int TIMEOUT_MS   = 999999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_ms,
    input  logic        start_n,
    input  logic        stop_n,
    output logic        led_go,
    output logic [19:0] ms_value,
    output logic        msg_en,
    output logic [23:0] msg_digits,
    output logic        new_best
);
    localparam logic [19:0] TIMEOUT = 20'(TIMEOUT_MS);
    logic start_p, stop_p;
    btn_edge_sync u_start (.clk(clk), .reset_n(reset_n), .btn_n_i(start_n), .press_o(start_p));
    btn_edge_sync u_stop  (.clk(clk), .reset_n(reset_n), .btn_n_i(stop_n),  .press_o(stop_p));
    state_e state_q, state_d;
    logic [15:0] lfsr_q;
    logic [19:0] delay_q, delay_d, cnt_q, cnt_d, best_q, best_d, delay_load;
    logic        new_best_d, new_best_q, led_go_q, msg_en_q;
    logic [23:0] msg_q;
    assign delay_load = 20'(MIN_DELAY_MS) + 20'(lfsr_q[RAND_BITS-1:0]);
    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        new_best_d = 1'b0;
        case (state_q)
            IDLE, RESULT, FALSE_START: begin
                if (start_p) begin
                    state_d = WAIT_RAND;
                    delay_d = delay_load;
                end
            end
            WAIT_RAND: begin
                if (stop_p) state_d = FALSE_START;
                else if (tick_ms) begin
                    delay_d = delay_q - 20'd1;
                    if (delay_q <= 20'd1) begin
                        state_d = TIMING;
                        cnt_d   = '0;
                    end
                end
            end
            TIMING: begin
                // a stop press swallows a coincident tick so the pre-tick count is kept
                if (stop_p) begin
                    state_d = RESULT;
                    if (cnt_q < best_q) begin
                        best_d     = cnt_q;
                        new_best_d = 1'b1;
                    end
                end else if (tick_ms) begin
                    cnt_d   = (cnt_q >= TIMEOUT - 20'd1) ? TIMEOUT : cnt_q + 20'd1;
                    state_d = (cnt_q >= TIMEOUT - 20'd1) ? RESULT : TIMING;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // display outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lfsr_q     <= LFSR_SEED;
            delay_q    <= '0;
            cnt_q      <= '0;
            best_q     <= NO_BEST;
            new_best_q <= 1'b0;
            led_go_q   <= 1'b0;
            msg_en_q   <= 1'b1;
            msg_q      <= {6{CODE_OFF}};
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_next(lfsr_q);
            delay_q    <= delay_d;
            cnt_q      <= cnt_d;
            best_q     <= best_d;
            new_best_q <= new_best_d;
            led_go_q   <= state_d == TIMING;
            msg_en_q   <= !(state_d inside {TIMING, RESULT});
            msg_q      <= (state_d == FALSE_START) ? {CODE_OFF, CODE_OFF, CODE_OFF, CODE_E, CODE_R, CODE_R}
                                                   : {6{CODE_OFF}};
        end
    end
    assign led_go     = led_go_q;
    assign ms_value   = cnt_q;
    assign msg_en     = msg_en_q;
    assign msg_digits = msg_q;
    assign new_best   = new_best_q;
endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb_reaction_timer_ctrl: scoreboard bench; display-state changes are popped against queued expectations.
module tb_reaction_timer_ctrl;
    typedef struct packed {
        logic        led;
        logic        en;
        logic [23:0] dig;
        logic [19:0] ms;
        logic        nb;
    } ev_t;

    logic clk = 1'b0, reset_n = 1'b1, tick_ms = 1'b0, start_n = 1'b1, stop_n = 1'b1;
    logic        led_go, msg_en, new_best;
    logic [19:0] ms_value;
    logic [23:0] msg_digits;
    int checks = 0, failures = 0, tcnt = 0, d;
    ev_t exp_q[$];
    logic [19:0] best_m = 20'hFFFFF, last_m = 20'd0;
    logic [15:0] m_lfsr;

    reaction_timer_ctrl #(.MIN_DELAY_MS(4), .RAND_BITS(2), .TIMEOUT_MS(50)) dut (
        .clk(clk), .reset_n(reset_n), .tick_ms(tick_ms), .start_n(start_n), .stop_n(stop_n),
        .led_go(led_go), .ms_value(ms_value), .msg_en(msg_en), .msg_digits(msg_digits), .new_best(new_best)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        tcnt = (tcnt + 1) % 4;
        tick_ms = (tcnt == 0);
    end

    // reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic ev_t mk(input logic l, input logic e, input logic [23:0] g, input logic [19:0] m, input logic n);
        return {l, e, g, m, n};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic push_wait(); exp_q.push_back(mk(0, 1, 24'hFFFFFF, last_m, 0)); endtask
    task automatic push_go();   exp_q.push_back(mk(1, 0, 24'hFFFFFF, 20'd0, 0));  endtask
    task automatic push_fs();   exp_q.push_back(mk(0, 1, 24'hFFFEAA, last_m, 0)); endtask
    task automatic push_res(input logic [19:0] n);
        logic nb;
        nb = n < best_m;
        exp_q.push_back(mk(0, 0, 24'hFFFFFF, n, nb));
        if (nb) best_m = n;
        last_m = n;
    endtask

    // monitor: any change of led/en/digits, or a new_best pulse, is one DUT event
    initial begin
        ev_t cur, prev, e;
        prev = mk(0, 1, 24'hFFFFFF, 20'd0, 0);
        forever begin
            @(posedge clk);
            #1;
            cur = {led_go, msg_en, msg_digits, ms_value, new_best};
            if (!reset_n) prev = mk(0, 1, 24'hFFFFFF, 20'd0, 0);
            else begin
                if (cur.led != prev.led || cur.en != prev.en || cur.dig != prev.dig || cur.nb) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event got led=%0b en=%0b dig=%h ms=%0d nb=%0b",
                                 cur.led, cur.en, cur.dig, cur.ms, cur.nb);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            failures++;
                            $display("FAIL event got led=%0b en=%0b dig=%h ms=%0d nb=%0b expected led=%0b en=%0b dig=%h ms=%0d nb=%0b",
                                     cur.led, cur.en, cur.dig, cur.ms, cur.nb, e.led, e.en, e.dig, e.ms, e.nb);
                        end
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic start_trial(input bit hold, output int dl);
        @(negedge clk) start_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 dl = 4 + int'(m_lfsr[1:0]);
        @(posedge clk);
        @(negedge clk) if (!hold) start_n = 1'b1;
    endtask

    task automatic wait_go(input int dl);
        int k = 0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            if (tick_ms) k++;
            #1;
            if (led_go) break;
        end
        chk("go_seen", led_go, 1);
        chk("go_delay_ticks", k, dl);
    endtask

    // count n ticks, optionally slip one clk so the press lands on a tick edge, then press stop
    task automatic stop_after(input int n, input bit sim);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (tick_ms) k++;
        end
        if (sim) @(posedge clk);
        @(negedge clk) stop_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) stop_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_led_go", led_go, 0);
        chk("rst_ms_value", ms_value, 0);
        chk("rst_msg_en", msg_en, 1);
        chk("rst_msg_digits", msg_digits, 24'hFFFFFF);
        chk("rst_new_best", new_best, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        // normal trial, then slower, then faster
        push_go(); push_res(7);
        start_trial(0, d); wait_go(d); stop_after(7, 0);
        push_wait(); push_go(); push_res(9);
        start_trial(0, d); wait_go(d); stop_after(9, 0);
        push_wait(); push_go(); push_res(3);
        start_trial(0, d); wait_go(d); stop_after(3, 0);
        stop_after(0, 0);
        // false start, then restart with stop coinciding with a tick at count 5
        push_wait(); push_fs();
        start_trial(0, d); stop_after(2, 0);
        push_wait(); push_go(); push_res(5);
        start_trial(0, d); wait_go(d); stop_after(5, 1);
        // start and stop pressed together in WAIT_RAND
        push_wait(); push_fs();
        start_trial(0, d);
        repeat (4) @(posedge clk);
        @(negedge clk) begin start_n = 1'b0; stop_n = 1'b0; end
        repeat (3) @(posedge clk);
        @(negedge clk) begin start_n = 1'b1; stop_n = 1'b1; end
        repeat (3) @(posedge clk);
        // stop on the final delay tick
        push_wait(); push_fs();
        start_trial(0, d); stop_after(d - 1, 1);
        // timeout
        push_wait(); push_go(); push_res(50);
        start_trial(0, d); wait_go(d);
        for (int n = 0; n < 1000 && led_go; n++) @(posedge clk) #1;
        chk("timeout_reached", led_go, 0);
        chk("timeout_ms", ms_value, 50);
        // start held across the whole trial and beyond; best still 3
        push_wait(); push_go(); push_res(4);
        start_trial(1, d); wait_go(d); stop_after(4, 0);
        repeat (40) @(posedge clk);
        @(negedge clk) start_n = 1'b1;
        repeat (4) @(posedge clk);
        // reset mid-TIMING
        push_wait(); push_go();
        start_trial(0, d); wait_go(d);
        repeat (6) @(posedge clk);
        @(negedge clk) reset_n = 1'b0;
        #1;
        chk("midrst_led_go", led_go, 0);
        chk("midrst_msg_digits", msg_digits, 24'hFFFFFF);
        chk("midrst_msg_en", msg_en, 1);
        chk("midrst_ms_value", ms_value, 0);
        best_m = 20'hFFFFF;
        last_m = 20'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        // best was cleared, so a slow time is a new best
        push_go(); push_res(9);
        start_trial(0, d); wait_go(d); stop_after(9, 0);
        repeat (10) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
